// File: rtl/serial_pkg.sv
// Shared definitions for the 1-bit-per-clock serial link.
// The transmitter and the receiver both use these, so they agree on framing and parity.
package serial_pkg;

  localparam int unsigned DATA_BITS_DEFAULT = 7;
  localparam int unsigned FRAME_LEN         = DATA_BITS_DEFAULT + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  // Even parity bit for a payload; callers zero-extend, which leaves parity unchanged.
  function automatic logic parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/serial_receiver_if.sv
// Consumer-side valid/ack handshake of the serial receiver.
interface serial_receiver_if #(
  parameter int unsigned DATA_BITS = serial_pkg::DATA_BITS_DEFAULT
);
  logic                 data_ack;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    input  data_ack,
    output data_out, data_valid, parity_err, frame_err, overrun
  );

  modport slave (
    output data_ack,
    input  data_out, data_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/serial_in_sync.sv
// Optional flop chain ahead of the sampler; resets to the idle-high line level.
module serial_in_sync #(
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q = d;
    end else begin : g_chain
      logic [SYNC_STAGES-1:0] chain;

      always_ff @(posedge clk) begin
        if (rst) begin
          chain <= '1;
        end else begin
          chain[0] <= d;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign q = chain[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/serial_receiver.sv
// Receive end of the serial link: start, LSB-first payload, even parity, stop.
// Delivers each frame on a valid/ack handshake with parity, framing and overrun status.
module serial_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_DEFAULT,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic              busy,
  serial_receiver_if.master rx
);

  localparam int unsigned          CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DATA_BITS - 1);

  logic s;

  serial_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (s)
  );

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      S_IDLE: begin
        if (!s) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        // Shifting in at the MSB lands d0 in bit 0 after DATA_BITS samples,
        // the same result as writing shift_reg[cnt].
        shift_d = {s, shift_q[DATA_BITS-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_PARITY;
      end
      S_PARITY: begin
        par_d   = s;
        state_d = S_STOP;
      end
      S_STOP: begin
        state_d = s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A commit on the same edge as an ack takes priority over the ack.
    if (state_q == S_STOP) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      perr_d  = par_q ^ parity(32'(shift_q));
      ferr_d  = ~s;
      ovr_d   = valid_q & ~rx.data_ack;
    end else if (valid_q && rx.data_ack) begin
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign rx.data_out   = data_q;
  assign rx.data_valid = valid_q;
  assign rx.parity_err = perr_q;
  assign rx.frame_err  = ferr_q;
  assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed and randomised frames against a frame-level reference model of the receiver.
module tb_serial_receiver;

  localparam int unsigned DB = 7;

  logic clk = 1'b0;
  logic rst;
  logic serial_in;
  logic busy;

  int checks = 0;
  int errors = 0;

  // Reference: what the consumer should see, tracked per whole frame.
  logic [DB-1:0] m_data;
  logic          m_valid, m_perr, m_ferr, m_ovr;

  serial_receiver_if #(.DATA_BITS(DB)) rx_if ();

  serial_receiver #(
    .DATA_BITS   (DB),
    .SYNC_STAGES (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .busy      (busy),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk7(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk7({tag, ".data"},  rx_if.data_out,   m_data);
    chk1({tag, ".valid"}, rx_if.data_valid, m_valid);
    chk1({tag, ".perr"},  rx_if.parity_err, m_perr);
    chk1({tag, ".ferr"},  rx_if.frame_err,  m_ferr);
    chk1({tag, ".ovr"},   rx_if.overrun,    m_ovr);
  endtask

  task automatic model_reset();
    m_data = '0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // One clock with the given line level and ack; not used on commit edges.
  task automatic step(input logic b, input logic ack);
    serial_in = b;
    rx_if.data_ack = ack;
    @(posedge clk); #1;
    if (ack && m_valid) begin
      m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end
    rx_if.data_ack = 1'b0;
  endtask

  // Full frame; the held output must not change until the stop-bit edge.
  task automatic send_frame(input logic [DB-1:0] d, input logic p, input logic stop,
                            input logic ack_commit, input string tag);
    step(1'b0, 1'b0);
    chk1({tag, ".busy_start"}, busy, 1'b1);
    for (int i = 0; i < int'(DB); i++) begin
      step(d[i], 1'b0);
      chk1({tag, ".busy_data"}, busy, 1'b1);
      chk1({tag, ".valid_early"}, rx_if.data_valid, m_valid);
    end
    step(p, 1'b0);
    chk1({tag, ".valid_par"}, rx_if.data_valid, m_valid);
    serial_in = stop;
    rx_if.data_ack = ack_commit;
    @(posedge clk); #1;
    rx_if.data_ack = 1'b0;
    m_ovr   = m_valid && !ack_commit;
    m_valid = 1'b1;
    m_data  = d;
    m_perr  = (p != (^d));
    m_ferr  = !stop;
    check_outputs(tag);
    chk1({tag, ".busy_stop"}, busy, !stop);
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          p, stop, ackc;
    int unsigned   gap, low;

    rst = 1'b1;
    serial_in = 1'b1;
    rx_if.data_ack = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    chk1("reset.busy", busy, 1'b0);
    rst = 1'b0;

    // 1: clean 0x55, latency checked by send_frame, then ack
    step(1'b1, 1'b0);
    send_frame(7'h55, 1'b0, 1'b1, 1'b0, "t1");
    step(1'b1, 1'b1);
    check_outputs("t1.ack");

    // 2: parity error, then a correctly odd-weight payload
    send_frame(7'h55, 1'b1, 1'b1, 1'b0, "t2a");
    step(1'b1, 1'b1);
    send_frame(7'h7F, 1'b1, 1'b1, 1'b0, "t2b");
    step(1'b1, 1'b1);

    // 3: missing stop bit, line held low, then recovery
    send_frame(7'h2A, 1'b1, 1'b0, 1'b0, "t3");
    repeat (5) begin
      step(1'b0, 1'b0);
      chk1("t3.busy_break", busy, 1'b1);
      check_outputs("t3.break");
    end
    step(1'b1, 1'b0);
    chk1("t3.busy_idle", busy, 1'b0);
    check_outputs("t3.idle");
    step(1'b1, 1'b1);
    send_frame(7'h01, 1'b1, 1'b1, 1'b0, "t3b");
    step(1'b1, 1'b1);

    // 4: back-to-back with ack on the second commit edge
    send_frame(7'h01, 1'b1, 1'b1, 1'b0, "t4a");
    send_frame(7'h7E, 1'b0, 1'b1, 1'b1, "t4b");
    step(1'b1, 1'b1);

    // 5: overrun, then ack clears flags but data holds
    send_frame(7'h11, 1'b0, 1'b1, 1'b0, "t5a");
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    send_frame(7'h22, 1'b0, 1'b1, 1'b0, "t5b");
    step(1'b1, 1'b1);
    check_outputs("t5.ack");

    // 6: reset mid-frame after d3 of 0x33
    step(1'b0, 1'b0);
    d = 7'h33;
    for (int i = 0; i < 4; i++) step(d[i], 1'b0);
    rst = 1'b1;
    serial_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_outputs("t6.rst");
    chk1("t6.busy", busy, 1'b0);
    send_frame(7'h44, 1'b0, 1'b1, 1'b0, "t6");
    step(1'b1, 1'b1);

    // Randomised frames, gaps, acks, parity and stop faults
    for (int n = 0; n < 30; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < int'(gap); g++) begin
        step(1'b1, 1'($urandom_range(0, 1)));
        check_outputs("rnd.gap");
      end
      d    = DB'($urandom);
      p    = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      ackc = 1'($urandom_range(0, 1));
      send_frame(d, p, stop, ackc, "rnd");
      if (!stop) begin
        low = $urandom_range(0, 3);
        for (int k = 0; k < int'(low); k++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk1("rnd.busy_recover", busy, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
